// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch constants, state encoding and the legal-fetch-address check.
package fetch_ctrl_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] PC_MIN   = 32'h0000_3000;
  localparam logic [31:0] PC_MAX   = 32'h0000_6ffc;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // A fetch is legal only when word aligned and inside the instruction window.
  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= PC_MIN) && (pc <= PC_MAX);
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_redirect_sel.sv
// Priority select of the fetch redirect: exc_req > eret > branch > jump.
// Purely combinational; branch/jump are masked while decode is stalled.
module pc_redirect_sel
  import fetch_ctrl_pkg::*;
(
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        stall_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_target_o
);

  always_comb begin
    redirect_valid_o  = 1'b0;
    redirect_target_o = '0;
    if (exc_req_i) begin
      redirect_valid_o  = 1'b1;
      redirect_target_o = EXC_VEC;
    end else if (eret_i) begin
      redirect_valid_o  = 1'b1;
      redirect_target_o = epc_i;
    end else if (!stall_i && branch_i) begin
      redirect_valid_o  = 1'b1;
      redirect_target_o = branch_target_i;
    end else if (!stall_i && jump_i) begin
      redirect_valid_o  = 1'b1;
      redirect_target_o = jump_target_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one IM request at a time, fills a single decode slot.
// Issue-to-slot latency is 2+ cycles; a new fetch is issued only when the slot is free.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_adel
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        flush_q, flush_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        adel_q, adel_d;

  logic        redir_vld;
  logic [31:0] redir_tgt;
  logic        consume;
  logic        slot_free;

  pc_redirect_sel u_sel (
    .exc_req_i        (exc_req),
    .eret_i           (eret),
    .epc_i            (epc),
    .branch_i         (branch),
    .branch_target_i  (branch_target),
    .jump_i           (jump),
    .jump_target_i    (jump_target),
    .stall_i          (stall),
    .redirect_valid_o (redir_vld),
    .redirect_target_o(redir_tgt)
  );

  assign consume   = valid_q & ~stall;
  assign slot_free = ~valid_q | consume;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    flush_d  = flush_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    adel_d   = adel_q;

    if (consume) valid_d = 1'b0;

    if (redir_vld) begin
      pc_d     = redir_tgt;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      if (state_q == WAIT) begin
        // An in-flight request cannot be cancelled on the IM port; remember to drop its data.
        if (imem_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          flush_d = 1'b0;
        end else begin
          flush_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!halted_q && slot_free) begin
            if (pc_legal(pc_q)) begin
              state_d = WAIT;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end else begin
              valid_d  = 1'b1;
              instr_d  = '0;
              ifpc_d   = pc_q;
              adel_d   = 1'b1;
              halted_d = 1'b1;
            end
          end
        end
        WAIT: begin
          if (imem_ready) begin
            state_d = IDLE;
            req_d   = 1'b0;
            if (flush_q) begin
              flush_d = 1'b0;
            end else begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              ifpc_d  = addr_q;
              adel_d  = 1'b0;
              pc_d    = pc_q + 32'd4;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= PC_RESET;
      halted_q <= 1'b0;
      flush_q  <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ifpc_q   <= '0;
      adel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      flush_q  <= flush_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      adel_q   <= adel_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_adel   = adel_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a transaction-level model predicts fetch addresses and slot contents.
module tb_fetch_ctrl;

  localparam logic [31:0] M_RESET = 32'h0000_3000;
  localparam logic [31:0] M_EXC   = 32'h0000_4180;
  localparam logic [31:0] M_MIN   = 32'h0000_3000;
  localparam logic [31:0] M_MAX   = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_req, eret, branch, jump, stall, imem_ready;
  logic [31:0] epc, branch_target, jump_target, imem_rdata;
  logic        imem_req, if_valid, if_adel;
  logic [31:0] imem_addr, if_instr, if_pc;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .eret(eret), .epc(epc),
    .branch(branch), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_adel(if_adel)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } slot_t;

  slot_t       slot_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] m_pc;
  bit          m_flushed;
  int          total = 0;
  int          bad = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= M_MIN) && (a <= M_MAX);
  endfunction

  // Whatever the PC is now, the machine will next either fetch it or report AdEL on it.
  task automatic push_next();
    slot_t s;
    if (legal(m_pc)) fetch_q.push_back(m_pc);
    else begin
      s.pc = m_pc; s.instr = '0; s.adel = 1'b1;
      slot_q.push_back(s);
    end
  endtask

  task automatic apply_model(input logic req_c);
    bit          redir;
    logic [31:0] tgt;
    slot_t       s;
    if (!rst) begin
      slot_q.delete(); fetch_q.delete();
      m_pc = M_RESET; m_flushed = 0;
      push_next();
      return;
    end
    redir = 1; tgt = '0;
    if (exc_req) tgt = M_EXC;
    else if (eret) tgt = epc;
    else if (!stall && branch) tgt = branch_target;
    else if (!stall && jump) tgt = jump_target;
    else redir = 0;
    if (redir) begin
      if (req_c) m_flushed = !imem_ready;
      slot_q.delete(); fetch_q.delete();
      m_pc = tgt;
      push_next();
    end else if (req_c && imem_ready) begin
      if (m_flushed) m_flushed = 0;
      else begin
        s.pc = m_pc; s.instr = imem_rdata; s.adel = 1'b0;
        slot_q.push_back(s);
        m_pc = m_pc + 32'd4;
        push_next();
      end
    end
  endtask

  task automatic tick();
    logic rq;
    rq = imem_req;
    @(posedge clk);
    #1;
    apply_model(rq);
  endtask

  task automatic clr();
    exc_req = 0; eret = 0; branch = 0; jump = 0; stall = 0; imem_ready = 0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && imem_req !== 1'b1; i++) begin
      clr(); tick();
    end
    check1("wait_req_timeout", imem_req, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check1("rst_imem_req", imem_req, 1'b0);
    check32("rst_imem_addr", imem_addr, 32'h0);
    check1("rst_if_valid", if_valid, 1'b0);
    check32("rst_if_instr", if_instr, 32'h0);
    check32("rst_if_pc", if_pc, 32'h0);
    check1("rst_if_adel", if_adel, 1'b0);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 9))
      0: return 32'h0000_6ff8;
      1: return 32'h0000_6ffc;
      2: return 32'h0000_7000;
      3: return 32'h0000_2ffc;
      4: return M_MIN + 32'h0000_0102;
      default: return M_MIN + {$urandom_range(0, 32'h0fff), 2'b00};
    endcase
  endfunction

  task automatic run_rand(input int n, input int p_stall, input int p_ready,
                          input int p_redir, input int p_rst);
    for (int i = 0; i < n; i++) begin
      clr();
      rst = ($urandom_range(0, 999) < p_rst) ? 1'b0 : 1'b1;
      stall = ($urandom_range(0, 99) < p_stall);
      imem_ready = (imem_req === 1'b1) && ($urandom_range(0, 99) < p_ready);
      imem_rdata = $urandom;
      if ($urandom_range(0, 99) < p_redir) begin
        case ($urandom_range(0, 3))
          0: exc_req = 1;
          1: begin eret = 1; epc = pick_target(); end
          2: begin branch = 1; branch_target = pick_target(); end
          default: begin jump = 1; jump_target = pick_target(); end
        endcase
      end
      tick();
    end
    rst = 1;
  endtask

  // Monitor: checks every new IM request and every slot that decode actually takes.
  logic        prev_req = 1'b0;
  logic        prev_blocked = 1'b0;
  logic        have_exp = 1'b0;
  logic [31:0] cur_exp = '0;

  always @(negedge clk) begin
    bit    redir_c;
    slot_t s;
    redir_c = exc_req | eret | (~stall & (branch | jump));
    if (imem_req === 1'b1) begin
      if (!prev_req) begin
        check1("issue_while_slot_held", prev_blocked, 1'b0);
        if (fetch_q.size() == 0) begin
          total++; bad++; have_exp = 0;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else begin
          cur_exp = fetch_q.pop_front();
          have_exp = 1;
          check32("imem_addr", imem_addr, cur_exp);
        end
      end else if (have_exp) begin
        check32("imem_addr_hold", imem_addr, cur_exp);
      end
    end
    if (rst === 1'b1 && if_valid === 1'b1 && !stall && !redir_c) begin
      if (slot_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_slot: got pc %h expected empty slot", if_pc);
      end else begin
        s = slot_q.pop_front();
        check32("slot_pc", if_pc, s.pc);
        check32("slot_instr", if_instr, s.instr);
        check1("slot_adel", if_adel, s.adel);
      end
    end
    prev_req = (imem_req === 1'b1);
    prev_blocked = (if_valid === 1'b1) && (stall === 1'b1);
  end

  initial begin
    clr();
    epc = '0; branch_target = '0; jump_target = '0; imem_rdata = '0;
    rst = 0;
    tick(); tick();
    check_reset_outputs();
    rst = 1;

    // Sequential fetch from the reset vector.
    for (int n = 0; n < 3; n++) begin
      wait_req();
      clr(); tick();
      imem_ready = 1; imem_rdata = 32'h1000_0000 + n; tick();
      clr(); tick();
    end

    // Slot held by a stalled decode blocks further issue.
    wait_req();
    imem_ready = 1; imem_rdata = 32'h2222_0003; tick();
    clr(); stall = 1;
    for (int i = 0; i < 5; i++) tick();
    check1("stall_no_req", imem_req, 1'b0);
    check1("stall_valid", if_valid, 1'b1);
    check32("stall_if_pc", if_pc, 32'h0000_300c);
    check32("stall_if_instr", if_instr, 32'h2222_0003);
    run_rand(10, 0, 60, 0, 0);

    // Branch while waiting: late data is discarded.
    wait_req();
    branch = 1; branch_target = 32'h0000_3100; tick();
    clr(); tick(); tick();
    imem_ready = 1; imem_rdata = 32'hdead_beef; tick();
    clr();
    check1("late_data_dropped", if_valid, 1'b0);
    wait_req();
    check32("branch_addr", imem_addr, 32'h0000_3100);

    // Exception under stall coinciding with a response, then eret.
    exc_req = 1; stall = 1; imem_ready = 1; imem_rdata = 32'hbad0_0001; tick();
    clr();
    check1("exc_data_dropped", if_valid, 1'b0);
    wait_req();
    check32("exc_addr", imem_addr, M_EXC);
    eret = 1; epc = 32'h0000_3010; tick();
    clr(); imem_ready = 1; tick();
    clr(); wait_req();
    check32("eret_addr", imem_addr, 32'h0000_3010);

    // Jump out of the fetch window halts with AdEL until the next exception.
    imem_ready = 1; imem_rdata = 32'h3333_0000; tick();
    clr(); jump = 1; jump_target = 32'h0000_7000; tick();
    clr(); stall = 1; tick();
    check1("adel_valid", if_valid, 1'b1);
    check32("adel_pc", if_pc, 32'h0000_7000);
    check1("adel_flag", if_adel, 1'b1);
    check32("adel_instr", if_instr, 32'h0);
    check1("adel_no_req", imem_req, 1'b0);
    clr();
    for (int i = 0; i < 8; i++) tick();
    check1("halted_no_req", imem_req, 1'b0);
    check1("halted_slot_empty", if_valid, 1'b0);
    exc_req = 1; tick();
    clr(); wait_req();
    check32("unhalt_addr", imem_addr, M_EXC);

    // Reset mid-transaction with a response in the same cycle.
    rst = 0; imem_ready = 1; imem_rdata = 32'h4444_4444; tick();
    rst = 1; clr();
    check_reset_outputs();
    wait_req();
    check32("post_reset_addr", imem_addr, M_RESET);

    run_rand(4000, 30, 40, 8, 3);
    run_rand(1500, 10, 80, 2, 0);

    clr();
    for (int i = 0; i < 4; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
